// File: rtl/fxp_pkg.sv
// -----------------------------------------------------------------------------
// fxp_pkg
// Shared definitions for the sequential fixed-point multiplier:
//   - rounding-mode encodings carried on i_rnd_mode
//   - FSM state encoding of fxp_mult_seq (also visible on its dbg_state port)
//   - round_up(): the round-increment decision used by fxp_round
// -----------------------------------------------------------------------------
package fxp_pkg;

   // Rounding modes. Encoding 2'b11 is not named and behaves as truncation.
   localparam logic [1:0] RND_TRUNC     = 2'b00;  // toward zero (magnitude truncation)
   localparam logic [1:0] RND_HALF_AWAY = 2'b01;  // half away from zero
   localparam logic [1:0] RND_CONV      = 2'b10;  // half to even

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } fsm_state_t;

   // Decide whether the truncated magnitude must be incremented.
   // Rounding acts on the magnitude, so "away from zero" is simply "up".
   function automatic logic round_up(input logic [1:0] mode,
                                     input logic       guard,
                                     input logic       sticky,
                                     input logic       lsb);
      logic up;
      up = 1'b0;
      case (mode)
         RND_HALF_AWAY: up = guard;
         RND_CONV:      up = guard & (sticky | lsb);
         default:       up = 1'b0;
      endcase
      return up;
   endfunction

endpackage

// File: rtl/fxp_round.sv
// -----------------------------------------------------------------------------
// fxp_round
// Combinational back end of the multiplier: rounds a 2N-bit unsigned product
// magnitude at bit Q, applies the sign, detects overflow of the N-bit signed
// result and optionally saturates.
//
// Configuration macro: FXP_MULT_SAT_EN
//   defined   -> overflowing results clamp to the most positive/negative value
//   undefined -> overflowing results wrap (low N bits of the signed result)
//
// Ports:
//   mag    in  2N  unsigned product magnitude |A|*|B|
//   neg    in  1   result sign (1 = negative)
//   mode   in  2   rounding mode (fxp_pkg RND_*)
//   result out N   signed rounded result
//   ovr    out 1   rounded result not representable in N signed bits
// -----------------------------------------------------------------------------
module fxp_round
   import fxp_pkg::*;
#(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic [2*N-1:0] mag,
   input  logic           neg,
   input  logic [1:0]     mode,
   output logic [N-1:0]   result,
   output logic           ovr
);

   localparam int W = 2 * N;

   // Bits Q-2..0 form the sticky field; empty (all-zero mask) when Q == 1.
   localparam logic [W-1:0] STICKY_MASK = (W'(1) << (Q - 1)) - W'(1);
   // Largest representable magnitudes for positive and negative results.
   localparam logic [W-1:0] POS_LIMIT   = (W'(1) << (N - 1)) - W'(1);
   localparam logic [W-1:0] NEG_LIMIT   = (W'(1) << (N - 1));

   logic [W-1:0] shifted;
   logic [W-1:0] rmag;
   logic [N-1:0] signed_low;
   logic         guard;
   logic         sticky;
   logic         up;
   logic         big;

   always_comb begin
      shifted    = mag >> Q;
      guard      = mag[Q-1];
      sticky     = |(mag & STICKY_MASK);
      up         = round_up(mode, guard, sticky, shifted[0]);
      // shifted < 2^(W-Q), so the increment cannot carry out of W bits.
      rmag       = shifted + W'(up);
      big        = neg ? (rmag > NEG_LIMIT) : (rmag > POS_LIMIT);
      // Negating a zero magnitude gives zero, so -0 never appears.
      signed_low = neg ? (~rmag[N-1:0] + N'(1)) : rmag[N-1:0];
      ovr        = big;
`ifdef FXP_MULT_SAT_EN
      if (big) begin
         result = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end else begin
         result = signed_low;
      end
`else
      result     = signed_low;
`endif
   end

endmodule

// File: rtl/fxp_mult_seq.sv
// -----------------------------------------------------------------------------
// fxp_mult_seq
// Sequential signed Q-format multiplier: result = round((A*B) >> Q).
// One radix-2 shift-add step per cycle on operand magnitudes, then one cycle
// of rounding / sign / overflow handling in fxp_round.
//
// Configuration macro: FXP_MULT_SAT_EN (saturate on overflow, see fxp_round)
//
// Handshake: an operation is accepted on a rising edge where i_valid and
// o_ready are both high (o_ready is high only in IDLE, inputs seen elsewhere
// are ignored, nothing is queued); a result is consumed on a rising edge
// where o_valid and i_ready are both high. o_result/ovr hold while o_valid
// is high and i_ready is low.
//
// Ports:
//   i_clk          in  1  clock, rising edge
//   i_rst          in  1  synchronous active-high reset
//   i_valid        in  1  operands presented
//   o_ready        out 1  able to accept operands (IDLE)
//   i_multiplicand in  N  signed operand A
//   i_multiplier   in  N  signed operand B
//   i_rnd_mode     in  2  rounding mode, captured with the operands
//   o_valid        out 1  result available (DONE)
//   i_ready        in  1  consumer accepts result
//   o_result       out N  signed rounded product
//   ovr            out 1  rounded result overflowed N signed bits
//   dbg_state      out 2  current FSM state
// -----------------------------------------------------------------------------
module fxp_mult_seq
   import fxp_pkg::*;
#(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [N-1:0]     i_multiplicand,
   input  logic [N-1:0]     i_multiplier,
   input  logic [1:0]       i_rnd_mode,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [N-1:0]     o_result,
   output logic             ovr,
   output fsm_state_t       dbg_state
);

   localparam int CW = $clog2(N) + 1;

   fsm_state_t       state;
   logic [2*N-1:0]   acc;      // {partial sum, remaining multiplier bits}
   logic [N-1:0]     mcand;    // |A|
   logic [CW-1:0]    cnt;
   logic             neg;
   logic [1:0]       mode;

   logic [N-1:0]     mag_a;
   logic [N-1:0]     mag_b;
   logic [N:0]       step_sum;
   logic [N-1:0]     rnd_result;
   logic             rnd_ovr;

   // Two's complement negation of -2^(N-1) yields 2^(N-1) as an unsigned
   // N-bit value, so the most negative operand keeps its full magnitude.
   always_comb begin
      mag_a    = i_multiplicand[N-1] ? (~i_multiplicand + N'(1)) : i_multiplicand;
      mag_b    = i_multiplier[N-1]   ? (~i_multiplier   + N'(1)) : i_multiplier;
      step_sum = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? mcand : {N{1'b0}})};
   end

   fxp_round #(.Q(Q), .N(N)) u_round (
      .mag    (acc),
      .neg    (neg),
      .mode   (mode),
      .result (rnd_result),
      .ovr    (rnd_ovr)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         o_ready  <= 1'b1;
         o_valid  <= 1'b0;
         o_result <= '0;
         ovr      <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         mode     <= RND_TRUNC;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_valid && o_ready) begin
                  mcand   <= mag_a;
                  acc     <= {{N{1'b0}}, mag_b};
                  neg     <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                  mode    <= i_rnd_mode;
                  cnt     <= '0;
                  o_ready <= 1'b0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Add |A| into the upper half when the current multiplier bit
               // is set, then shift the whole register right by one.
               acc <= {step_sum, acc[N-1:1]};
               if (cnt == CW'(N - 1)) begin
                  cnt   <= '0;
                  state <= ST_FINAL;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_FINAL: begin
               o_result <= rnd_result;
               ovr      <= rnd_ovr;
               o_valid  <= 1'b1;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (o_valid && i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               o_ready <= 1'b1;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_fxp_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_fxp_mult_seq
// Directed bench for fxp_mult_seq at N=32, Q=15 (1.0 = 32768).
// Expected values are hand-computed; overflow expectations follow the
// FXP_MULT_SAT_EN build setting.
// -----------------------------------------------------------------------------
module tb_fxp_mult_seq;
   import fxp_pkg::*;

   localparam int N = 32;
   localparam int Q = 15;
   localparam int LAT = N + 1;

   logic          i_clk;
   logic          i_rst;
   logic          i_valid;
   logic          o_ready;
   logic [N-1:0]  i_multiplicand;
   logic [N-1:0]  i_multiplier;
   logic [1:0]    i_rnd_mode;
   logic          o_valid;
   logic          i_ready;
   logic [N-1:0]  o_result;
   logic          ovr;
   fsm_state_t    dbg_state;

   int n_cmp;
   int n_err;
   int cyc;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [1:0]   m;
      logic [N-1:0] res;
      logic         ov;
   } vec_t;

   fxp_mult_seq #(.Q(Q), .N(N)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_multiplicand (i_multiplicand),
      .i_multiplier   (i_multiplier),
      .i_rnd_mode     (i_rnd_mode),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_result       (o_result),
      .ovr            (ovr),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset block ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks (no checking) ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [1:0] m, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (o_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge i_clk); #1;
      end
      if (ok) begin
         i_valid        = 1'b1;
         i_multiplicand = a;
         i_multiplier   = b;
         i_rnd_mode     = m;
         @(posedge i_clk); #1;
         // Scramble inputs after the accept edge; they must not matter.
         i_valid        = 1'b0;
         i_multiplicand = $urandom;
         i_multiplier   = $urandom;
         i_rnd_mode     = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic wait_valid(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge i_clk); #1;
         lat++;
         if (o_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge i_clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      i_rst = 1'b1;
      step(3);
      i_rst = 1'b0;
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0 ||
          ovr !== 1'b0 || dbg_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL reset: ready=%b valid=%b result=%h ovr=%b state=%0d, required 1 0 0 0 0",
                  o_ready, o_valid, o_result, ovr, dbg_state);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int lat;
      start_op(32'd49152, 32'd65536, RND_HALF_AWAY, ok);
      wait_valid(lat, ok);
      n_cmp++;
      if (!ok || lat !== LAT) begin
         n_err++;
         $display("FAIL basic_latency: got %0d cycles (seen=%0b), required %0d", lat, ok, LAT);
      end
      n_cmp++;
      if (o_result !== 32'd98304 || ovr !== 1'b0 || o_ready !== 1'b0) begin
         n_err++;
         $display("FAIL basic_result: result=%0d ovr=%b ready=%b, required 98304 0 0",
                  o_result, ovr, o_ready);
      end
      step(1);
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         n_err++;
         $display("FAIL basic_consume: valid=%b ready=%b, required 0 1", o_valid, o_ready);
      end
   endtask

   task automatic run_table(input string name, input vec_t v[$]);
      bit ok;
      int lat;
      foreach (v[k]) begin
         start_op(v[k].a, v[k].b, v[k].m, ok);
         wait_valid(lat, ok);
         n_cmp++;
         if (!ok || lat !== LAT || o_result !== v[k].res || ovr !== v[k].ov) begin
            n_err++;
            $display("FAIL %s[%0d]: a=%h b=%h m=%0d got res=%h ovr=%b lat=%0d, required res=%h ovr=%b lat=%0d",
                     name, k, v[k].a, v[k].b, v[k].m, o_result, ovr, lat, v[k].res, v[k].ov, LAT);
         end
         step(1);
      end
   endtask

   task automatic test_rounding();
      vec_t v[$];
      v.push_back('{32'd1,          32'd16384, 2'd0, 32'd0,          1'b0});
      v.push_back('{32'd1,          32'd16384, 2'd1, 32'd1,          1'b0});
      v.push_back('{32'd1,          32'd16384, 2'd2, 32'd0,          1'b0});
      v.push_back('{32'd3,          32'd16384, 2'd0, 32'd1,          1'b0});
      v.push_back('{32'd3,          32'd16384, 2'd1, 32'd2,          1'b0});
      v.push_back('{32'd3,          32'd16384, 2'd2, 32'd2,          1'b0});
      v.push_back('{32'hFFFFFFFF,   32'd16384, 2'd1, 32'hFFFFFFFF,   1'b0});
      v.push_back('{32'hFFFFFFFF,   32'd16384, 2'd2, 32'd0,          1'b0});
      v.push_back('{32'd3,          32'd16384, 2'd3, 32'd1,          1'b0});
      v.push_back('{32'hFFFFFFFD,   32'd16384, 2'd0, 32'hFFFFFFFF,   1'b0});
      v.push_back('{32'hFFFFFFFD,   32'd16384, 2'd1, 32'hFFFFFFFE,   1'b0});
      v.push_back('{32'd5,          32'd16384, 2'd2, 32'd2,          1'b0});
      v.push_back('{32'd1,          32'd24576, 2'd2, 32'd1,          1'b0});
      v.push_back('{32'd0,          32'hFFFFFFFB, 2'd1, 32'd0,       1'b0});
      run_table("round", v);
   endtask

   task automatic test_overflow();
      vec_t v[$];
      // (2^32-1)*2^14: truncated 0x7FFFFFFF with guard set.
      v.push_back('{32'd65537,      32'd1073725440, 2'd0, 32'h7FFFFFFF, 1'b0});
      v.push_back('{32'hFFFEFFFF,   32'd1073725440, 2'd1, 32'h80000000, 1'b0});
      v.push_back('{32'h80000000,   32'd32768,      2'd1, 32'h80000000, 1'b0});
`ifdef FXP_MULT_SAT_EN
      v.push_back('{32'd65537,      32'd1073725440, 2'd1, 32'h7FFFFFFF, 1'b1});
      v.push_back('{32'h7FFFFFFF,   32'h7FFFFFFF,   2'd0, 32'h7FFFFFFF, 1'b1});
      v.push_back('{32'h80000000,   32'h80000000,   2'd0, 32'h7FFFFFFF, 1'b1});
      v.push_back('{32'h80000000,   32'h7FFFFFFF,   2'd0, 32'h80000000, 1'b1});
`else
      v.push_back('{32'd65537,      32'd1073725440, 2'd1, 32'h80000000, 1'b1});
      v.push_back('{32'h7FFFFFFF,   32'h7FFFFFFF,   2'd0, 32'hFFFE0000, 1'b1});
      v.push_back('{32'h80000000,   32'h80000000,   2'd0, 32'h00000000, 1'b1});
      v.push_back('{32'h80000000,   32'h7FFFFFFF,   2'd0, 32'h00010000, 1'b1});
`endif
      run_table("ovf", v);
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      int bad;
      i_ready = 1'b0;
      start_op(32'd49152, 32'd65536, RND_HALF_AWAY, ok);
      wait_valid(lat, ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL bp_valid: o_valid never rose, required within %0d cycles", LAT);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         i_valid        = (i % 2 == 0);
         i_multiplicand = 32'd7;
         i_multiplier   = 32'd32768;
         step(1);
         if (o_valid !== 1'b1 || o_result !== 32'd98304 || ovr !== 1'b0 || o_ready !== 1'b0) bad++;
      end
      i_valid = 1'b0;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL bp_hold: %0d of 10 cycles changed (valid=%b res=%0d ovr=%b ready=%b), required 0",
                  bad, o_valid, o_result, ovr, o_ready);
      end
      i_ready = 1'b1;
      step(1);
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: valid=%b ready=%b, required 0 1", o_valid, o_ready);
      end
      step(3);
      n_cmp++;
      if (dbg_state !== ST_IDLE || o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_no_queue: state=%0d valid=%b, required 0 0", dbg_state, o_valid);
      end
   endtask

   task automatic test_reset_mid_busy();
      bit ok;
      int lat;
      start_op(32'd3, 32'd16384, RND_HALF_AWAY, ok);
      step(4);
      n_cmp++;
      if (dbg_state !== ST_BUSY) begin
         n_err++;
         $display("FAIL rst_mid_state: state=%0d, required %0d", dbg_state, ST_BUSY);
      end
      i_rst = 1'b1;
      step(1);
      i_rst = 1'b0;
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0 || ovr !== 1'b0 ||
          dbg_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL rst_mid: ready=%b valid=%b result=%h ovr=%b state=%0d, required 1 0 0 0 0",
                  o_ready, o_valid, o_result, ovr, dbg_state);
      end
      start_op(32'd49152, 32'd65536, RND_TRUNC, ok);
      wait_valid(lat, ok);
      n_cmp++;
      if (!ok || lat !== LAT || o_result !== 32'd98304 || ovr !== 1'b0) begin
         n_err++;
         $display("FAIL rst_recover: res=%0d ovr=%b lat=%0d, required 98304 0 %0d",
                  o_result, ovr, lat, LAT);
      end
      step(1);
   endtask

   task automatic test_back_to_back();
      int t[$];
      int res_bad;
      logic prev;
      i_ready        = 1'b1;
      i_valid        = 1'b1;
      i_multiplicand = 32'd3;
      i_multiplier   = 32'd16384;
      i_rnd_mode     = RND_HALF_AWAY;
      prev    = o_valid;
      res_bad = 0;
      for (int i = 0; i < 200 && t.size() < 2; i++) begin
         step(1);
         if (o_valid && !prev) begin
            t.push_back(cyc);
            if (o_result !== 32'd2 || ovr !== 1'b0) res_bad++;
         end
         prev = o_valid;
      end
      i_valid = 1'b0;
      n_cmp++;
      if (t.size() != 2 || (t[1] - t[0]) != N + 3) begin
         n_err++;
         $display("FAIL b2b_period: %0d results, interval %0d, required 2 results %0d apart",
                  t.size(), (t.size() == 2) ? t[1] - t[0] : -1, N + 3);
      end
      n_cmp++;
      if (res_bad != 0) begin
         n_err++;
         $display("FAIL b2b_result: %0d bad results (last res=%0d ovr=%b), required 0 (res 2 ovr 0)",
                  res_bad, o_result, ovr);
      end
      step(2);
   endtask

   // ---------------- sequencer and final report ----------------
   initial begin
      n_cmp          = 0;
      n_err          = 0;
      i_rst          = 1'b1;
      i_valid        = 1'b0;
      i_ready        = 1'b1;
      i_multiplicand = '0;
      i_multiplier   = '0;
      i_rnd_mode     = 2'd0;
      @(posedge i_clk); #1;
      test_reset();
      test_basic();
      test_rounding();
      test_overflow();
      test_backpressure();
      test_reset_mid_busy();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fxp_mult_seq.md
FXP_MULT_SEQ -- requirements
Module: fxp_mult_seq

Interface
REQ-001 Parameter Q, default 15, fractional bit count; legal range 1 <= Q <= N-1.
REQ-002 Parameter N, default 32, operand/result width in bits (signed two's complement Q-format); N >= 4.
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  operands presented.
REQ-006 o_ready  output  1  block can accept operands; high only in IDLE.
REQ-007 i_multiplicand  input  N  signed operand A.
REQ-008 i_multiplier  input  N  signed operand B.
REQ-009 i_rnd_mode  input  2  rounding mode, sampled with operands: 00 truncate toward zero, 01 round half away from zero, 10 convergent (half to even), 11 treated as 00.
REQ-010 o_valid  output  1  result available.
REQ-011 i_ready  input  1  consumer accepts result.
REQ-012 o_result  output  N  signed rounded product (A*B) >> Q.
REQ-013 ovr  output  1  exact rounded result not representable in N signed bits; valid with o_valid.

Function
REQ-014 FSM states IDLE, BUSY, FINAL, DONE; IDLE->BUSY on i_valid & o_ready at edge; BUSY->FINAL after exactly N iteration cycles; FINAL->DONE after one cycle; DONE->IDLE on i_valid... no: DONE->IDLE on o_valid & i_ready.
REQ-015 Accept captures |A|, |B| as N-bit unsigned magnitudes, result sign = sign(A) XOR sign(B), and i_rnd_mode; later input changes do not affect the operation.
REQ-016 BUSY performs one radix-2 shift-add step per cycle into a 2N-bit unsigned accumulator; |-2^(N-1)| = 2^(N-1) handled without loss.
REQ-017 FINAL rounds the magnitude at bit Q per captured mode (guard = bit Q-1, sticky = OR of bits Q-2..0), applies sign, computes ovr, registers o_result and ovr.
REQ-018 Latency: o_valid rises N+1 cycles after the accept edge; throughput one operation per N+3 cycles with i_ready held high.
REQ-019 o_valid high only in DONE; o_result and ovr stable while o_valid=1 and i_ready=0 (indefinite backpressure allowed).
REQ-020 A zero magnitude result yields o_result=0 regardless of sign; ovr=0.
REQ-021 ovr=1 when the signed rounded result < -2^(N-1) or > 2^(N-1)-1; rounding carry that causes overflow counts.
REQ-022 i_valid while not in IDLE is ignored (o_ready=0); no queuing.

Reset
REQ-023 i_rst at any edge, including mid-BUSY/FINAL/DONE, forces IDLE next cycle and discards the operation.
REQ-024 Reset values: o_ready=1, o_valid=0, o_result=0, ovr=0, accumulator and counter 0.

Configuration
REQ-025 Macro FXP_MULT_SAT_EN defined: on overflow o_result clamps to 2^(N-1)-1 (positive) or -2^(N-1) (negative), ovr=1.
REQ-026 FXP_MULT_SAT_EN undefined: on overflow o_result = low N bits of the signed rounded result (wrap), ovr=1.

Structure
REQ-027 Shared package fxp_pkg holds rounding-mode constants (RND_TRUNC, RND_HALF_AWAY, RND_CONV) and FSM state encoding.
REQ-028 One sub-module fxp_round: combinational magnitude rounding, sign application, overflow detect and saturation, instantiated by FINAL logic.

Verification (N=32, Q=15, 1.0=32768)
REQ-029 A=49152 (1.5), B=65536 (2.0), mode 01 -> o_result=98304, ovr=0, o_valid exactly 33 cycles after accept.
REQ-030 A=1, B=16384 (product 0.5 LSB): mode 00 -> 0, 01 -> 1, 10 -> 0; A=3 same B: 00 -> 1, 01 -> 2, 10 -> 2; A=-1, B=16384: 01 -> -1, 10 -> 0.
REQ-031 A=B=0x7FFFFFFF -> ovr=1; with FXP_MULT_SAT_EN o_result=0x7FFFFFFF, without = wrapped low 32 bits; A=0x80000000, B=32768 -> o_result=0x80000000, ovr=0.
REQ-032 Hold i_ready=0 for 10 cycles in DONE -> o_valid, o_result, ovr unchanged, o_ready=0; i_valid pulses ignored.
REQ-033 Assert i_rst on BUSY cycle 5 -> next cycle o_ready=1, o_valid=0, o_result=0, ovr=0; new operation then completes correctly.
